adler32: RTL and testbench
==========================

ADLER32 -- requirements
Module: adler32

Interface
REQ-001 Parameter DATA_WD, 32, input data and checksum width; only 32 is supported.
REQ-002 Parameter NUM_WD, 2, width of the byte-count field.
REQ-003 Port clk  input  1  single clock; all logic is rising-edge.
REQ-004 Port rst  input  1  synchronous, active-high reset.
REQ-005 Port start_i  input  1  one-cycle pulse that opens a new checksum frame.
REQ-006 Port val_i  input  1  data beat valid.
REQ-007 Port dat_i  input  32  data bytes, MSB-first: byte0 = [31:24].
REQ-008 Port num_i  input  2  valid bytes minus 1, MSB-aligned (0 = [31:24] only; 3 = all four bytes).
REQ-009 Port lst_i  input  1  qualifies the final beat of the frame; valid only with val_i.
REQ-010 Port done_o  output  1  one-cycle pulse when the checksum is final.
REQ-011 Port val_o  output  1  asserted together with done_o.
REQ-012 Port dat_o  output  32  checksum {B[15:0], A[15:0]}, zlib trailer order.

Function
REQ-013 Checksum is Adler-32 (RFC 1950): A = 1 + sum(bytes) mod 65521; B = sum of successive A values mod 65521.
REQ-014 FSM has two states:
- IDLE -> ACC on start_i.
- ACC -> IDLE on an accepted beat with lst_i.
- ACC -> ACC on start_i (restart).
REQ-015 start_i loads A = 1, B = 0 from any state.
REQ-016 A beat with val_i in the same cycle as start_i is processed against the initial values (A = 1, B = 0).
REQ-017 val_i in IDLE without start_i is ignored; no state changes.
REQ-018 One beat is accepted per cycle with no backpressure; back-to-back beats are supported at full rate.
REQ-019 Per beat with n = num_i + 1 bytes b0..b(n-1):
- A' = (A + sum bi) mod 65521.
- B' = (B + n*A + sum (n-i)*bi) mod 65521.
- Both are computed in one cycle.
REQ-020 Reduction arithmetic:
- A pre-reduction sum is ≤ 66540: one conditional subtract.
- B pre-reduction sum is ≤ 5*65520 + 2550 < 6*65521: select from compares against k*65521, k = 1..5.
- Intermediates are at least 19 bits wide.
REQ-021 Bytes outside the num_i range are ignored, whatever their value.
REQ-022 Latency: done_o and val_o pulse exactly 1 cycle after the lst_i beat is accepted; dat_o holds the final {B,A} in that cycle.
REQ-023 dat_o holds its value after done_o until the next start_i or rst; done_o and val_o are 0 at all other times.
REQ-024 start_i in the same cycle as a pending done_o pulse does not suppress that pulse; the new frame starts cleanly.
REQ-025 A frame of 5552 or more bytes (the zlib NMAX boundary) produces a correct result; reduction happens on every beat.

Reset
REQ-026 rst dominates start_i and val_i.
REQ-027 On rst the block sets: state IDLE, A = 1, B = 0, done_o = 0, val_o = 0, dat_o = 32'h0000_0000.
REQ-028 rst mid-frame discards the partial frame; no done_o follows.

Structure
REQ-029 The shared package holds: DATA_WD, NUM_WD, the ADLER_MOD = 65521 constant, and the FSM state encoding.
REQ-030 A combinational sub-module adler32_step (inputs A, B, dat, num; outputs A', B') contains the per-beat update and reduction; adler32 holds the FSM, registers and outputs.

Verification
REQ-031 start, then "abc" as one beat (dat 0x61626300, num 2, lst) -> done_o 1 cycle later, dat_o = 0x024D0127.
REQ-032 start, then "Wikipedia" as 0x57696B69/3, 0x70656469/3, 0x61000000/0 + lst, back-to-back -> dat_o = 0x11E60398.
REQ-033 start + val_i same cycle, dat 0x00xxxxxx, num 0, lst -> dat_o = 0x00010001; the don't-care bytes are randomized.
REQ-034 8192 beats of 0xFFFFFFFF, then lst -> dat_o matches the golden C model; all intermediate A, B < 65521.
REQ-035 rst asserted mid-frame, then "abc" frame -> no spurious done_o; dat_o = 0x024D0127.
REQ-036 start_i mid-frame, then "abc" -> checksum equals the fresh-frame value 0x024D0127.

Source files
------------

// File: rtl/adler32_pkg.sv
// Shared constants and FSM encoding for the Adler-32 checksum block.
package adler32_pkg;

  localparam int unsigned DATA_WD   = 32;
  localparam int unsigned NUM_WD    = 2;
  localparam int unsigned ADLER_MOD = 65521;
  localparam int unsigned HALF_WD   = 16;
  // Wide enough for B + 4*A + weighted byte sum (< 6*65521)
  localparam int unsigned SUM_WD    = 19;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_ACC  = 1'b1
  } state_e;

endpackage

// File: rtl/adler32_step.sv
// Combinational per-beat Adler-32 update of up to four MSB-first bytes.
module adler32_step
  import adler32_pkg::*;
(
  input  logic [HALF_WD-1:0] a_i,
  input  logic [HALF_WD-1:0] b_i,
  input  logic [DATA_WD-1:0] dat_i,
  input  logic [NUM_WD-1:0]  num_i,
  output logic [HALF_WD-1:0] a_o,
  output logic [HALF_WD-1:0] b_o
);

  localparam logic [SUM_WD-1:0] MOD_X1 = SUM_WD'(1 * ADLER_MOD);
  localparam logic [SUM_WD-1:0] MOD_X2 = SUM_WD'(2 * ADLER_MOD);
  localparam logic [SUM_WD-1:0] MOD_X3 = SUM_WD'(3 * ADLER_MOD);
  localparam logic [SUM_WD-1:0] MOD_X4 = SUM_WD'(4 * ADLER_MOD);
  localparam logic [SUM_WD-1:0] MOD_X5 = SUM_WD'(5 * ADLER_MOD);

  logic [2:0]        n_bytes;
  logic [9:0]        byte_sum;
  logic [11:0]       weight_sum;
  logic [SUM_WD-1:0] a_sum;
  logic [SUM_WD-1:0] b_sum;
  logic [SUM_WD-1:0] b_red;

  assign n_bytes = 3'(num_i) + 3'd1;

  // Plain and position-weighted sums over the valid bytes only
  always_comb begin
    byte_sum   = '0;
    weight_sum = '0;
    for (int i = 0; i < 4; i++) begin
      if (i <= int'(num_i)) begin
        byte_sum   = byte_sum + 10'(dat_i[DATA_WD-1-8*i -: 8]);
        weight_sum = weight_sum
                   + 12'(dat_i[DATA_WD-1-8*i -: 8]) * 12'(int'(n_bytes) - i);
      end
    end
  end

  // A: sum stays below 2*MOD, so one conditional subtract suffices
  always_comb begin
    a_sum = SUM_WD'(a_i) + SUM_WD'(byte_sum);
    if (a_sum >= MOD_X1) begin
      a_o = HALF_WD'(a_sum - MOD_X1);
    end else begin
      a_o = HALF_WD'(a_sum);
    end
  end

  // B: sum stays below 6*MOD, so pick the largest multiple not exceeding it
  always_comb begin
    b_sum = SUM_WD'(b_i) + SUM_WD'(n_bytes) * SUM_WD'(a_i) + SUM_WD'(weight_sum);
    if (b_sum >= MOD_X5) begin
      b_red = b_sum - MOD_X5;
    end else if (b_sum >= MOD_X4) begin
      b_red = b_sum - MOD_X4;
    end else if (b_sum >= MOD_X3) begin
      b_red = b_sum - MOD_X3;
    end else if (b_sum >= MOD_X2) begin
      b_red = b_sum - MOD_X2;
    end else if (b_sum >= MOD_X1) begin
      b_red = b_sum - MOD_X1;
    end else begin
      b_red = b_sum;
    end
    b_o = HALF_WD'(b_red);
  end

endmodule

// File: rtl/adler32.sv
// Streaming Adler-32 checksum: frame FSM, running A/B registers and result outputs.
module adler32
  import adler32_pkg::*;
#(
  parameter int unsigned DATA_WD = 32,
  parameter int unsigned NUM_WD  = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start_i,
  input  logic               val_i,
  input  logic [DATA_WD-1:0] dat_i,
  input  logic [NUM_WD-1:0]  num_i,
  input  logic               lst_i,
  output logic               done_o,
  output logic               val_o,
  output logic [DATA_WD-1:0] dat_o
);

  state_e               state_q, state_d;
  logic [HALF_WD-1:0]   a_q, a_d;
  logic [HALF_WD-1:0]   b_q, b_d;
  logic                 done_q, done_d;
  logic [DATA_WD-1:0]   dat_q, dat_d;

  logic [HALF_WD-1:0]   a_base;
  logic [HALF_WD-1:0]   b_base;
  logic [HALF_WD-1:0]   a_step;
  logic [HALF_WD-1:0]   b_step;
  logic                 accept;

  // A beat coinciding with start_i runs against the fresh initial values
  assign a_base = start_i ? HALF_WD'(1) : a_q;
  assign b_base = start_i ? HALF_WD'(0) : b_q;
  assign accept = val_i && (start_i || (state_q == ST_ACC));

  adler32_step u_step (
    .a_i   (a_base),
    .b_i   (b_base),
    .dat_i (dat_i),
    .num_i (num_i),
    .a_o   (a_step),
    .b_o   (b_step)
  );

  // Next-state, running sums and result capture
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    done_d  = 1'b0;
    dat_d   = dat_q;

    if (start_i) begin
      state_d = ST_ACC;
      a_d     = HALF_WD'(1);
      b_d     = HALF_WD'(0);
      dat_d   = '0;
    end

    if (accept) begin
      a_d = a_step;
      b_d = b_step;
      if (lst_i) begin
        state_d = ST_IDLE;
        done_d  = 1'b1;
        dat_d   = DATA_WD'({b_step, a_step});
      end
    end
  end

  // State and output registers, synchronous reset dominates everything
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      a_q     <= HALF_WD'(1);
      b_q     <= HALF_WD'(0);
      done_q  <= 1'b0;
      dat_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      done_q  <= done_d;
      dat_q   <= dat_d;
    end
  end

  assign done_o = done_q;
  assign val_o  = done_q;
  assign dat_o  = dat_q;

endmodule

// File: tb/tb_adler32.sv
// Directed self-checking bench for the Adler-32 block.
module tb_adler32;

  logic        clk;
  logic        rst;
  logic        start_i;
  logic        val_i;
  logic [31:0] dat_i;
  logic [1:0]  num_i;
  logic        lst_i;
  logic        done_o;
  logic        val_o;
  logic [31:0] dat_o;

  int errors = 0;
  int checks = 0;

  adler32 #(.DATA_WD(32), .NUM_WD(2)) dut (
    .clk     (clk),
    .rst     (rst),
    .start_i (start_i),
    .val_i   (val_i),
    .dat_i   (dat_i),
    .num_i   (num_i),
    .lst_i   (lst_i),
    .done_o  (done_o),
    .val_o   (val_o),
    .dat_o   (dat_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one clock; outputs are stable 1 time unit after the edge
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic s, input logic v, input logic [31:0] d,
                       input logic [1:0] n, input logic l);
    start_i = s;
    val_i   = v;
    dat_i   = d;
    num_i   = n;
    lst_i   = l;
  endtask

  task automatic idle_in();
    drive(1'b0, 1'b0, 32'h0, 2'd0, 1'b0);
  endtask

  // Start pulse, then "abc" as a single final beat with a don't-care tail byte
  task automatic abc_frame(input logic [7:0] tail);
    drive(1'b1, 1'b0, 32'h0, 2'd0, 1'b0);
    cyc();
    drive(1'b0, 1'b1, {24'h616263, tail}, 2'd2, 1'b1);
    cyc();
    idle_in();
  endtask

  logic [31:0] rnd;
  logic [31:0] ref_a;
  logic [31:0] ref_b;
  int          range_viol;

  initial begin
    rst = 1'b1;
    idle_in();
    cyc();
    cyc();
    chk("reset_done", 32'(done_o), 32'd0);
    chk("reset_val", 32'(val_o), 32'd0);
    chk("reset_dat", dat_o, 32'h0000_0000);
    rst = 1'b0;
    cyc();
    chk("idle_done", 32'(done_o), 32'd0);

    // "abc" single beat
    abc_frame(8'h00);
    chk("abc_done", 32'(done_o), 32'd1);
    chk("abc_val", 32'(val_o), 32'd1);
    chk("abc_dat", dat_o, 32'h024D_0127);
    cyc();
    chk("abc_done_pulse", 32'(done_o), 32'd0);
    chk("abc_dat_hold", dat_o, 32'h024D_0127);

    // val_i while idle without start_i is ignored
    drive(1'b0, 1'b1, 32'h1234_5678, 2'd3, 1'b1);
    cyc();
    idle_in();
    chk("idle_val_done", 32'(done_o), 32'd0);
    chk("idle_val_dat", dat_o, 32'h024D_0127);

    // Out-of-range byte ignored
    abc_frame(8'hA5);
    chk("mask_dat", dat_o, 32'h024D_0127);

    // "Wikipedia" back-to-back; start_i lands while done_o is still high
    chk("pend_done", 32'(done_o), 32'd1);
    drive(1'b1, 1'b0, 32'h0, 2'd0, 1'b0);
    cyc();
    chk("restart_clear_dat", dat_o, 32'h0);
    chk("restart_no_done", 32'(done_o), 32'd0);
    drive(1'b0, 1'b1, 32'h5769_6B69, 2'd3, 1'b0);
    cyc();
    chk("wiki_mid_done", 32'(done_o), 32'd0);
    drive(1'b0, 1'b1, 32'h7065_6469, 2'd3, 1'b0);
    cyc();
    drive(1'b0, 1'b1, 32'h6100_0000, 2'd0, 1'b1);
    cyc();
    idle_in();
    chk("wiki_done", 32'(done_o), 32'd1);
    chk("wiki_dat", dat_o, 32'h11E6_0398);

    // start + val + lst in one cycle, single byte 0x00, random tail bytes
    rnd = $urandom();
    drive(1'b1, 1'b1, {8'h00, rnd[23:0]}, 2'd0, 1'b1);
    cyc();
    idle_in();
    chk("onecyc_done", 32'(done_o), 32'd1);
    chk("onecyc_dat", dat_o, 32'h0001_0001);

    // rst mid-frame discards the frame, then a clean "abc"
    drive(1'b1, 1'b0, 32'h0, 2'd0, 1'b0);
    cyc();
    drive(1'b0, 1'b1, 32'h5769_6B69, 2'd3, 1'b0);
    cyc();
    rst = 1'b1;
    drive(1'b1, 1'b1, 32'h7065_6469, 2'd3, 1'b1);
    cyc();
    rst = 1'b0;
    idle_in();
    chk("rst_mid_done", 32'(done_o), 32'd0);
    chk("rst_mid_dat", dat_o, 32'h0);
    drive(1'b0, 1'b1, 32'h6100_0000, 2'd0, 1'b1);
    cyc();
    idle_in();
    chk("rst_mid_ignored", 32'(done_o), 32'd0);
    abc_frame(8'h00);
    chk("rst_abc_dat", dat_o, 32'h024D_0127);

    // start_i mid-frame restarts the checksum
    drive(1'b1, 1'b0, 32'h0, 2'd0, 1'b0);
    cyc();
    drive(1'b0, 1'b1, 32'h5769_6B69, 2'd3, 1'b0);
    cyc();
    drive(1'b0, 1'b1, 32'h7065_6469, 2'd3, 1'b0);
    cyc();
    abc_frame(8'h00);
    chk("restart_abc_done", 32'(done_o), 32'd1);
    chk("restart_abc_dat", dat_o, 32'h024D_0127);

    // 8192 beats of 0xFF bytes, well past the NMAX boundary
    ref_a = 32'd1;
    ref_b = 32'd0;
    for (int i = 0; i < 8192 * 4; i++) begin
      ref_a = (ref_a + 32'd255) % 32'd65521;
      ref_b = (ref_b + ref_a) % 32'd65521;
    end
    range_viol = 0;
    drive(1'b1, 1'b0, 32'h0, 2'd0, 1'b0);
    cyc();
    for (int i = 0; i < 8192; i++) begin
      drive(1'b0, 1'b1, 32'hFFFF_FFFF, 2'd3, (i == 8191));
      cyc();
      if (dut.a_q >= 16'd65521 || dut.b_q >= 16'd65521) range_viol++;
      if (i != 8191 && done_o) range_viol++;
    end
    idle_in();
    chk("long_done", 32'(done_o), 32'd1);
    chk("long_dat", dat_o, {ref_b[15:0], ref_a[15:0]});
    chk("long_range", 32'(range_viol), 32'd0);
    cyc();
    chk("long_done_pulse", 32'(done_o), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
